// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder/subtractor controller.
// One decimal-adjusted digit adder is reused across all DIGITS positions,
// least significant digit first, one digit per clock. Subtraction uses the
// nine's complement of B with an initial carry of 1 (ten's complement).
module bcd_serial_adder_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sub,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  cout,
   output logic                  err
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_reg, state_next;
   logic [IDX_W-1:0]      idx_reg;
   logic                  carry_reg;
   logic                  sub_reg;
   logic [4*DIGITS-1:0]   a_reg, b_reg;
   logic [4*DIGITS-1:0]   work_reg, work_next;

   logic [3:0]            a_dig_arr [DIGITS];
   logic [3:0]            b_dig_arr [DIGITS];
   logic [DIGITS-1:0]     bad_dig;
   logic                  operand_bad;
   logic [3:0]            a_dig, b_dig, bd, digit;
   logic [4:0]            sum;
   logic                  carry_next;
   logic                  last_dig;

   // Per-digit views of the latched operands, validity check of the live
   // operands (checked at the accepting edge), and the working-result slot
   // write for the digit currently being processed.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign a_dig_arr[gi] = a_reg[gi*4 +: 4];
      assign b_dig_arr[gi] = b_reg[gi*4 +: 4];
      assign bad_dig[gi]   = (a[gi*4 +: 4] > 4'd9) || (b[gi*4 +: 4] > 4'd9);
      assign work_next[gi*4 +: 4] = (idx_reg == IDX_W'(gi)) ? digit
                                                            : work_reg[gi*4 +: 4];
   end

   assign operand_bad = |bad_dig;
   assign a_dig       = a_dig_arr[idx_reg];
   assign b_dig       = b_dig_arr[idx_reg];
   assign last_dig    = (idx_reg == LAST_IDX);
   assign busy        = (state_reg == RUN);
   assign done        = (state_reg == DONE);

   // Single digit stage: optional nine's complement, 5-bit add, decimal adjust.
   always_comb begin
      bd         = sub_reg ? (4'd9 - b_dig) : b_dig;
      sum        = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, carry_reg};
      digit      = sum[3:0];
      carry_next = 1'b0;
      if (sum > 5'd9) begin
         digit      = 4'(sum - 5'd10);
         carry_next = 1'b1;
      end
   end

   // Next-state logic; DONE accepts a new start exactly like IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (start)
               state_next = operand_bad ? DONE : RUN;
            else
               state_next = IDLE;
         end
         RUN: begin
            if (last_dig)
               state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Operand latching, digit sequencing and result publication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         work_reg  <= '0;
         result    <= '0;
         cout      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  sub_reg   <= sub;
                  idx_reg   <= '0;
                  carry_reg <= sub;
                  work_reg  <= '0;
                  if (operand_bad) begin
                     result <= '0;
                     cout   <= 1'b0;
                     err    <= 1'b1;
                  end
               end
            end
            RUN: begin
               work_reg  <= work_next;
               carry_reg <= carry_next;
               if (last_dig) begin
                  result <= work_next;
                  cout   <= carry_next;
                  err    <= 1'b0;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Testbench for bcd_serial_adder_ctrl: directed vectors with literal
// expectations plus randomized operations against a decimal-arithmetic model.
module tb_bcd_serial_adder_ctrl;

   localparam int D = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             sub = 1'b0;
   logic [4*D-1:0]   a = '0;
   logic [4*D-1:0]   b = '0;
   logic             busy, done, cout, err;
   logic [4*D-1:0]   result;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .cout(cout), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal model: returns {err, cout, result}.
   function automatic logic [4*D+1:0] model(input logic [4*D-1:0] x, input logic [4*D-1:0] y,
                                            input logic s);
      longint xa, ya, p, r;
      logic bad, c;
      logic [4*D-1:0] o;
      xa = 0; ya = 0; p = 1; bad = 1'b0; c = 1'b0; o = '0;
      for (int i = D - 1; i >= 0; i--) begin
         if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) bad = 1'b1;
         xa = xa * 10 + longint'(x[i*4 +: 4]);
         ya = ya * 10 + longint'(y[i*4 +: 4]);
         p  = p * 10;
      end
      if (bad) return {1'b1, 1'b0, {4*D{1'b0}}};
      if (!s) begin
         r = xa + ya;
         c = (r >= p);
         if (c) r = r - p;
      end else begin
         r = xa - ya;
         c = (r >= 0);
         if (!c) r = r + p;
      end
      for (int i = 0; i < D; i++) begin
         o[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return {1'b0, c, o};
   endfunction

   logic [4*D+1:0] mv;
   assign mv = model(a, b, sub);

   // Cycle-level expectation: an accepted valid op keeps busy for D cycles,
   // then done for one; an invalid op goes straight to done.
   logic           exp_busy = 1'b0, exp_done = 1'b0, exp_cout = 1'b0, exp_err = 1'b0;
   logic [4*D-1:0] exp_result = '0, p_result = '0;
   logic           p_cout = 1'b0;
   int             m_left = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_busy <= 1'b0; exp_done <= 1'b0; exp_cout <= 1'b0; exp_err <= 1'b0;
         exp_result <= '0; m_left <= 0;
      end else if (exp_busy) begin
         if (m_left == 1) begin
            exp_busy   <= 1'b0;
            exp_done   <= 1'b1;
            exp_result <= p_result;
            exp_cout   <= p_cout;
            exp_err    <= 1'b0;
         end
         m_left <= m_left - 1;
      end else begin
         exp_done <= 1'b0;
         if (start) begin
            if (mv[4*D+1]) begin
               exp_done <= 1'b1; exp_result <= '0; exp_cout <= 1'b0; exp_err <= 1'b1;
            end else begin
               exp_busy <= 1'b1; m_left <= D;
               p_result <= mv[4*D-1:0]; p_cout <= mv[4*D];
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("busy",   32'(busy),   32'(exp_busy));
      chk("done",   32'(done),   32'(exp_done));
      chk("result", 32'(result), 32'(exp_result));
      chk("cout",   32'(cout),   32'(exp_cout));
      chk("err",    32'(err),    32'(exp_err));
   end

   // Called #1 after an edge; k edges since E0 (inclusive) already elapsed.
   task automatic wait_done(input int k, output int lat);
      lat = k;
      forever begin
         @(negedge clk);
         if (done) break;
         if (lat > 20) begin
            chk("done_timeout", 32'(lat), 32'd0);
            break;
         end
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input logic [15:0] xa, input logic [15:0] xb, input logic s,
                         input logic lit, input logic [15:0] er, input logic ec,
                         input logic ee, input int elat);
      int lat;
      logic saw_busy;
      @(negedge clk);
      a = xa; b = xb; sub = s; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      saw_busy = busy;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      wait_done(1, lat);
      $display("op a=%h b=%h sub=%0d -> result=%h cout=%0d err=%0d latency=%0d",
               xa, xb, s, result, cout, err, lat);
      if (lit) begin
         chk("lit_result",  32'(result), 32'(er));
         chk("lit_cout",    32'(cout),   32'(ec));
         chk("lit_err",     32'(err),    32'(ee));
         chk("lit_latency", 32'(lat),    32'(elat));
         chk("lit_busy_after_start", 32'(saw_busy), 32'(!ee));
      end
   endtask

   function automatic logic [15:0] rand_bcd();
      logic [15:0] v;
      for (int i = 0; i < D; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) v[$urandom_range(0, D-1)*4 +: 4] = 4'($urandom_range(10, 15));
      return v;
   endfunction

   initial begin
      int lat;
      #2 rst = 1'b1;
      #20;
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_done",   32'(done),   32'd0);
      @(negedge clk) rst = 1'b0;

      run_op(16'h1234, 16'h5678, 1'b0, 1'b1, 16'h6912, 1'b0, 1'b0, 5);
      run_op(16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 5);
      run_op(16'h0009, 16'h0009, 1'b0, 1'b1, 16'h0018, 1'b0, 1'b0, 5);
      run_op(16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0, 5);
      run_op(16'h1234, 16'h5000, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0, 5);
      run_op(16'h4321, 16'h4321, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 5);
      run_op(16'h12A4, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1);
      run_op(16'h0002, 16'h0003, 1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 5);

      // start pulsed while busy is ignored
      @(negedge clk);
      a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 a = 16'h9999; b = 16'h9999; sub = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(4, lat);
      $display("op busy-ignore -> result=%h cout=%0d latency=%0d", result, cout, lat);
      chk("ignore_result",  32'(result), 32'h6912);
      chk("ignore_latency", 32'(lat),    32'd5);

      // back-to-back: start held through the done cycle
      @(negedge clk);
      a = 16'h0500; b = 16'h0500; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 wait_done(1, lat);
      $display("op b2b first -> result=%h cout=%0d latency=%0d", result, cout, lat);
      chk("b2b1_result", 32'(result), 32'h1000);
      a = 16'h3000; b = 16'h0001; sub = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(1, lat);
      $display("op b2b second -> result=%h cout=%0d latency=%0d", result, cout, lat);
      chk("b2b2_result",  32'(result), 32'h2999);
      chk("b2b2_cout",    32'(cout),   32'd1);
      chk("b2b2_latency", 32'(lat),    32'd5);

      // reset mid-run
      @(negedge clk);
      a = 16'h8888; b = 16'h1111; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_done",   32'(done),   32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout",   32'(cout),   32'd0);
      $display("op reset mid-run -> busy=%0d done=%0d result=%h", busy, done, result);
      @(negedge clk) rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("rst_no_done", 32'(done), 32'd0);
      end
      run_op(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 5);

      // randomized operations, model-checked every cycle
      for (int n = 0; n < 60; n++) begin
         logic [15:0] ra, rb;
         ra = rand_bcd();
         rb = rand_bcd();
         run_op(ra, rb, 1'($urandom), 1'b0, 16'h0, 1'b0, 1'b0, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Digit-serial controller that adds or subtracts two multi-digit packed-BCD operands by sequencing a single 4-bit BCD digit-add stage, one digit per clock, least significant digit first. It sits between operand registers and display or accumulator logic. Its role is to let one decimal-adjusted digit adder serve operands of any width. It handles start/busy/done sequencing, the carry chain between digits, ten's-complement subtraction and invalid-digit detection.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request an operation; sampled only when busy=0
- sub  in  1  0 = A+B, 1 = A−B; latched with start
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  in  4*DIGITS  operand B, packed BCD
- busy  out  1  high while digits are being processed
- done  out  1  one-cycle pulse when result/cout/err become valid
- result  out  4*DIGITS  packed-BCD result, held until next completion
- cout  out  1  add: decimal carry out; sub: 1 = no borrow (A≥B)
- err  out  1  operand contained a digit >9; held until next completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1 at a clock edge:
  - Latch a, b and sub into internal operand registers.
  - Check every digit of both operands.
  - If any digit is >9, go to DONE with err=1, result=0, cout=0.
  - Otherwise go to RUN with idx=0 and carry=sub, clearing the working result register.
- RUN, one digit per edge, for digit idx:
  - bd = sub ? 9−b[idx] : b[idx].
  - s = a[idx] + bd + carry, computed at 5-bit width (max 19).
  - If s>9: digit=s−10, carry=1. Else: digit=s, carry=0.
  - Write digit into working result slot idx.
  - If idx=DIGITS−1: copy the working result to result, set cout=carry and err=0, go to DONE. Otherwise idx+1.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - start is also accepted in DONE, with the same behaviour as in IDLE. The next state is then RUN, or DONE again on error.
- busy=1 only in RUN. start while busy=1 is ignored, and a/b/sub changes during RUN have no effect.
- Subtraction result: for A≥B, result=A−B and cout=1. For A<B, result is the ten's complement 10^DIGITS−(B−A) and cout=0.
- result, cout and err change only on the edge entering DONE; they are stable at all other times.

## Timing
- Reset (async, any state, mid-operation included) sets state=IDLE, idx=0, carry=0, busy=0, done=0, result=0, cout=0, err=0. An aborted operation produces no done.
- Valid operands:
  - start sampled at edge E0; busy=1 from E0 to E(DIGITS).
  - Digit k is processed at edge E(k+1).
  - done=1 and outputs valid in the cycle after E(DIGITS). Latency is DIGITS+1 edges from start to done (5 for DIGITS=4).
- Invalid operands: done=1 in the cycle after E0 (latency 1), and busy never rises.
- Back-to-back: start held high during the done cycle begins the next operation at that edge. Throughput is one operation per DIGITS+1 cycles.
- DIGITS=1 is legal: RUN lasts one cycle.
- The 9−digit, add and decimal adjust form one combinational path per cycle. There is no pipelining inside a digit.

## Test plan
- Add, carry ripples through the middle digits: a=0x1234, b=0x5678, sub=0 → done at start+5, result=0x6912, cout=0, err=0.
- Add, carry out of the top digit: a=0x9999, b=0x0001, sub=0 → result=0x0000, cout=1. Also a=0x0009, b=0x0009 → result=0x0018, cout=0 (checks s=18 is adjusted).
- Subtract, A≥B: a=0x5000, b=0x1234, sub=1 → result=0x3766, cout=1. Subtract, A<B: a=0x1234, b=0x5000, sub=1 → result=0x6234, cout=0. Equal operands 0x4321−0x4321 → result=0x0000, cout=1.
- Invalid digit: a=0x12A4, b=0x0001 → busy stays 0, done at start+1, err=1, result=0x0000, cout=0. A following valid operation clears err.
- Busy handling:
  - start pulsed with different operands at start+2 → ignored; first result unchanged.
  - start held through the done cycle → second op completes 5 cycles after the first done.
- Reset mid-run: assert rst at start+3 → all outputs 0 immediately, with no done. A new start after release produces a correct result.
